fifo_sync_ctrl: RTL and testbench

Synchronous ready/valid FIFO controller that owns the pointers and flags for an external single-clock two-port RAM. The RAM has a 1-cycle registered read and no reset.
- Controller drives the RAM's write and read ports.
- A 2-entry output buffer hides the RAM read latency so the FIFO sustains one pop per cycle.
- Sits between a producer stream and a consumer stream; the RAM is instantiated beside it at the FIFO top level.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_sync_ctrl_if.sv | 23 ++
 rtl/fifo_out_buf.sv | 62 ++++++
 rtl/fifo_sync_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_sync_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous FIFO controller.
package fifo_pkg;

    // Words held in the output buffer that hides the RAM read latency.
    localparam int unsigned OUT_BUF_DEPTH = 2;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Wrapping pointer increment: depth-1 rolls back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_sync_ctrl_if.sv
// Producer/consumer ready-valid streams of the FIFO controller.
interface fifo_sync_ctrl_if #(
    parameter int Width = 32
);
    logic             push_valid;
    logic             push_ready;
    logic [Width-1:0] push_data;
    logic             pop_valid;
    logic             pop_ready;
    logic [Width-1:0] pop_data;

    // Stream endpoints outside the FIFO (producer + consumer).
    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    // The FIFO controller.
    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry in-order register buffer in front of the consumer.
// Load and pop in the same cycle are both honoured; the owner never
// loads when full without popping, nor pops when empty.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic [1:0]       count_o
);
    logic [Width-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [1:0]       cnt_q, cnt_d;

    // Next entries/count: entry 0 is always the head.
    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        cnt_d = cnt_q;
        case ({load_i, pop_i})
            2'b10: begin
                if (cnt_q == 2'd0) d0_d = load_data_i;
                else               d1_d = load_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                d0_d  = d1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    d0_d = load_data_i;
                end else begin
                    d0_d = d1_q;
                    d1_d = load_data_i;
                end
            end
            default: ;
        endcase
    end

    // Buffer state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d0_q  <= '0;
            d1_q  <= '0;
            cnt_q <= '0;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = d0_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/fifo_sync_ctrl.sv
// Pointer/flag controller for a single-clock FIFO built on an external
// two-port RAM with 1-cycle registered read. A 2-entry output buffer
// hides the read latency so pops sustain one word per cycle.
// Optional macro FIFO_ERR_FLAG_EN enables sticky overflow/underflow flags.
module fifo_sync_ctrl
    import fifo_pkg::*;
#(
    parameter int Width = 32,
    parameter int Depth = 256,
    localparam int Aw = $clog2(Depth),
    localparam int Cw = $clog2(Depth + 3)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    fifo_sync_ctrl_if.slave  bus,
    output logic             ram_we_o,
    output logic [Aw-1:0]    ram_waddr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic             ram_re_o,
    output logic [Aw-1:0]    ram_raddr_o,
    input  logic [Width-1:0] ram_rdata_i,
    output logic [Cw-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic             underflow_o
);
    localparam logic [Aw:0] RamFull = (Aw + 1)'(Depth);

    logic [Aw-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [Aw:0]      ram_cnt_q, ram_cnt_d;
    logic             rd_inflight_q, rd_inflight_d;
    logic [1:0]       buf_cnt;
    logic [Width-1:0] buf_head;
    logic [2:0]       pending;
    logic             push_ready, pop_valid, push_fire, pop_fire, ram_re;

    // Ready depends only on registered RAM occupancy, never on pop_ready.
    assign push_ready = (ram_cnt_q < RamFull);
    assign pop_valid  = (buf_cnt != 2'd0);
    assign push_fire  = bus.push_valid & push_ready;
    assign pop_fire   = pop_valid & bus.pop_ready;

    // Issue a read only if the result is guaranteed a buffer slot.
    assign pending = {1'b0, buf_cnt} + {2'b00, rd_inflight_q} - {2'b00, pop_fire};
    assign ram_re  = (ram_cnt_q != '0) && (pending < 3'(OUT_BUF_DEPTH));

    // Pointer, occupancy and in-flight next state.
    always_comb begin
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        ram_cnt_d     = ram_cnt_q + (Aw + 1)'(push_fire) - (Aw + 1)'(ram_re);
        rd_inflight_d = ram_re;
        if (push_fire) wptr_d = Aw'(ptr_inc(32'(wptr_q), 32'(Depth)));
        if (ram_re)    rptr_d = Aw'(ptr_inc(32'(rptr_q), 32'(Depth)));
    end

    // Controller state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= rd_inflight_d;
        end
    end

    fifo_out_buf #(.Width(Width)) u_out_buf (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (rd_inflight_q),
        .load_data_i (ram_rdata_i),
        .pop_i       (pop_fire),
        .head_o      (buf_head),
        .count_o     (buf_cnt)
    );

    assign bus.push_ready = push_ready;
    assign bus.pop_valid  = pop_valid;
    assign bus.pop_data   = rst_ni ? buf_head : '0;

    assign ram_we_o    = push_fire;
    assign ram_waddr_o = wptr_q;
    assign ram_wdata_o = bus.push_data;
    assign ram_re_o    = ram_re;
    assign ram_raddr_o = rptr_q;

    assign count_o = Cw'(ram_cnt_q) + Cw'(rd_inflight_q) + Cw'(buf_cnt);
    assign full_o  = !push_ready;
    assign empty_o = (count_o == '0);

`ifdef FIFO_ERR_FLAG_EN
    fifo_err_t err_q, err_d;

    // Sticky error flags, cleared only by reset.
    always_comb begin
        err_d = err_q;
        if (bus.push_valid && !push_ready) err_d.overflow  = 1'b1;
        if (bus.pop_ready && !pop_valid)   err_d.underflow = 1'b1;
    end

    // Error flag register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) err_q <= '0;
        else         err_q <= err_d;
    end

    assign overflow_o  = err_q.overflow;
    assign underflow_o = err_q.underflow;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Randomized + directed bench for fifo_sync_ctrl (Width=8, Depth=4).
// Reference model: a word queue of FIFO contents plus sticky flag bits.
module tb_fifo_sync_ctrl;
    localparam int W   = 8;
    localparam int D   = 4;
    localparam int AW  = $clog2(D);
    localparam int CW  = $clog2(D + 3);
    localparam int CAP = D + 2;
`ifdef FIFO_ERR_FLAG_EN
    localparam logic FLAG_EN = 1'b1;
`else
    localparam logic FLAG_EN = 1'b0;
`endif

    logic          clk, rst_ni;
    logic          ram_we, ram_re, ovf, unf, full, empty;
    logic [AW-1:0] ram_waddr, ram_raddr;
    logic [W-1:0]  ram_wdata, ram_rdata;
    logic [CW-1:0] count;
    logic [W-1:0]  mem [D];

    fifo_sync_ctrl_if #(.Width(W)) bus ();

    fifo_sync_ctrl #(.Width(W), .Depth(D)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .bus         (bus),
        .ram_we_o    (ram_we),
        .ram_waddr_o (ram_waddr),
        .ram_wdata_o (ram_wdata),
        .ram_re_o    (ram_re),
        .ram_raddr_o (ram_raddr),
        .ram_rdata_i (ram_rdata),
        .count_o     (count),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (ovf),
        .underflow_o (unf)
    );

    // External RAM: registered read, no reset.
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_vec = 0, n_bad = 0;
    logic [W-1:0] q [$];
    logic       ovf_m = 1'b0, unf_m = 1'b0;
    int         cyc = 0, npop = 0, first_pop = -1, last_pop = -1, maxcnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic tick();
        logic         pf, qf, v, r;
        logic [W-1:0] pd;
        #1;
        v  = bus.push_valid;
        r  = bus.pop_ready;
        pf = v && bus.push_ready;
        qf = bus.pop_valid && r;
        pd = bus.push_data;
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(!bus.push_ready));
        if (q.size() < D)    chk("ready_room", 32'(bus.push_ready), 1);
        if (q.size() == CAP) chk("ready_cap", 32'(bus.push_ready), 0);
        if (q.size() == 0)   chk("valid_empty", 32'(bus.pop_valid), 0);
        if (qf && q.size() != 0) chk("pop_data", 32'(bus.pop_data), 32'(q[0]));
        chk("ram_collide", 32'(ram_we && ram_re && ram_waddr == ram_raddr), 0);
        chk("overflow", 32'(ovf), 32'(ovf_m));
        chk("underflow", 32'(unf), 32'(unf_m));
        @(posedge clk);
        if (pf) q.push_back(pd);
        if (qf && q.size() != 0) begin
            void'(q.pop_front());
            npop++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
        end
        if (FLAG_EN) begin
            ovf_m = ovf_m | (v && !bus.push_ready);
            unf_m = unf_m | (r && !bus.pop_valid);
        end
        cyc++;
        @(negedge clk);
        if (int'(count) > maxcnt) maxcnt = int'(count);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b0;
        #1;
        chk("rst_pop_data", 32'(bus.pop_data), 0);
        @(posedge clk);
        q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(bus.pop_valid), 0);
        chk("rst_ready", 32'(bus.push_ready), 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_flags", {30'd0, ovf, unf}, 0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        bus.pop_ready = 1'b0;
    endtask

    initial begin
        int k;
        rst_ni = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;
        @(negedge clk);
        do_reset();

        // Latency: single push into empty FIFO.
        bus.push_valid = 1'b1;
        bus.push_data  = 8'h11;
        tick();
        bus.push_valid = 1'b0;
        chk("lat_count1", 32'(count), 1);
        chk("lat_valid1", 32'(bus.pop_valid), 0);
        tick();
        chk("lat_valid2", 32'(bus.pop_valid), 0);
        tick();
        chk("lat_valid3", 32'(bus.pop_valid), 1);
        chk("lat_data3", 32'(bus.pop_data), 32'h11);
        drain(10);

        // Fill: offer 1..8, consumer stalled; only CAP words fit.
        k = 1;
        for (int i = 0; i < 10; i++) begin
            bus.push_valid = (k <= 8);
            bus.push_data  = 8'(k);
            #1;
            if (bus.push_valid && bus.push_ready) k++;
            tick();
        end
        bus.push_valid = 1'b0;
        chk("fill_accepted", k - 1, CAP);
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), CAP);
        npop = 0;
        drain(20);
        chk("fill_popped", npop, CAP);
        chk("fill_empty", 32'(empty), 1);

        // Streaming with wrap: 20 words, consumer always ready.
        npop = 0; first_pop = -1; maxcnt = 0; k = 0;
        bus.pop_ready = 1'b1;
        for (int i = 0; i < 60 && npop < 20; i++) begin
            bus.push_valid = (k < 20);
            bus.push_data  = 8'(k);
            #1;
            if (bus.push_valid && bus.push_ready) k++;
            tick();
        end
        bus.push_valid = 1'b0;
        chk("stream_popped", npop, 20);
        chk("stream_rate", last_pop - first_pop, 19);
        chk("stream_maxcnt", 32'(maxcnt <= 3), 1);

        // Backpressure: continuous push, pop_ready toggling.
        k = 0;
        for (int i = 0; i < 80; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'(k);
            bus.pop_ready  = i[0];
            #1;
            if (bus.push_ready) k++;
            tick();
        end
        drain(20);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.push_valid = ($urandom_range(0, 3) != 0);
            bus.push_data  = 8'($urandom);
            bus.pop_ready  = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain(20);

        // Reset mid-stream: 3 pushes leave 3 words held with a read in flight.
        bus.pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'h50 + 8'(i);
            tick();
        end
        bus.push_valid = 1'b0;
        chk("mid_count", 32'(count), 3);
        chk("mid_inflight", 32'(dut.rd_inflight_q), 1);
        do_reset();
        tick();
        chk("mid_valid_after", 32'(bus.pop_valid), 0);
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hAA;
        tick();
        bus.push_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_new_valid", 32'(bus.pop_valid), 1);
        chk("mid_new_data", 32'(bus.pop_data), 32'hAA);
        drain(10);

        // Error flags: pop while empty, then push while full.
        do_reset();
        bus.pop_ready = 1'b1;
        tick();
        bus.pop_ready = 1'b0;
        chk("err_underflow", 32'(unf), 32'(FLAG_EN));
        tick();
        chk("err_underflow_held", 32'(unf), 32'(FLAG_EN));
        chk("err_no_overflow", 32'(ovf), 0);
        k = 0;
        for (int i = 0; i < 12; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 8'hC0 + 8'(i);
            tick();
        end
        bus.push_valid = 1'b0;
        chk("err_overflow", 32'(ovf), 32'(FLAG_EN));
        chk("err_full_count", 32'(count), CAP);
        drain(20);
        chk("err_overflow_held", 32'(ovf), 32'(FLAG_EN));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
